// File: rtl/points_sched_pkg.sv
// Shared constants, FSM state encoding and byte-select helper for the frame point scheduler.
package points_sched_pkg;

  localparam logic [7:0] PKT_HEADER     = 8'hA5;
  localparam int         NUM_POINTS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    FCNT = 3'd2,
    NUM  = 3'd3,
    PT   = 3'd4,
    CHK  = 3'd5
  } state_e;

  // Point payload byte order on the wire: H high, H low, V high, V low.
  function automatic logic [7:0] coord_byte(input logic [15:0] h,
                                            input logic [15:0] v,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = h[15:8];
      2'd1:    b = h[7:0];
      2'd2:    b = v[15:8];
      default: b = v[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/points_frame_scheduler.sv
// Snapshots finder points at each VS falling edge and streams them as a framed,
// XOR-checked byte packet over valid/ready; also decimates, counts and drop-counts frames.
module points_frame_scheduler
  import points_sched_pkg::*;
#(
  parameter int NUM_POINTS  = NUM_POINTS_DEF,
  parameter int COORD_W     = 16,
  parameter int FRAME_DECIM = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VGA_VS,
  input  logic [COORD_W-1:0] i_POINTS_H0,
  input  logic [COORD_W-1:0] i_POINTS_H1,
  input  logic [COORD_W-1:0] i_POINTS_H2,
  input  logic [COORD_W-1:0] i_POINTS_H3,
  input  logic [COORD_W-1:0] i_POINTS_V0,
  input  logic [COORD_W-1:0] i_POINTS_V1,
  input  logic [COORD_W-1:0] i_POINTS_V2,
  input  logic [COORD_W-1:0] i_POINTS_V3,
  input  logic [15:0]        i_POINTS_NUM,
  output logic [7:0]         o_TX_DATA,
  output logic               o_TX_VALID,
  input  logic               i_TX_READY,
  output logic               o_BUSY,
  output logic [15:0]        o_FRAME_CNT,
  output logic [15:0]        o_DROP_CNT
);

  localparam int SLOTS = (NUM_POINTS < NUM_POINTS_DEF) ? NUM_POINTS : NUM_POINTS_DEF;
  localparam int N_W   = 3;
  localparam logic [7:0] DECIM_LAST = 8'(FRAME_DECIM - 1);

  logic               vs_q, vs_d;
  state_e             state_q, state_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]         decim_q, decim_d;
  logic [COORD_W-1:0] h_q [NUM_POINTS_DEF];
  logic [COORD_W-1:0] h_d [NUM_POINTS_DEF];
  logic [COORD_W-1:0] v_q [NUM_POINTS_DEF];
  logic [COORD_W-1:0] v_d [NUM_POINTS_DEF];
  logic [N_W-1:0]     n_q, n_d;
  logic [7:0]         fc_q, fc_d;
  logic [1:0]         pt_idx_q, pt_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]         chk_q, chk_d;

  logic [COORD_W-1:0] h_in [NUM_POINTS_DEF];
  logic [COORD_W-1:0] v_in [NUM_POINTS_DEF];
  logic [N_W-1:0]     n_clamped;
  logic               frame_end;
  logic               selected;
  logic               tx_vld;
  logic [7:0]         tx_dat;
  logic               tx_fire;
  logic               last_pt;

  assign h_in[0] = i_POINTS_H0;
  assign h_in[1] = i_POINTS_H1;
  assign h_in[2] = i_POINTS_H2;
  assign h_in[3] = i_POINTS_H3;
  assign v_in[0] = i_POINTS_V0;
  assign v_in[1] = i_POINTS_V1;
  assign v_in[2] = i_POINTS_V2;
  assign v_in[3] = i_POINTS_V3;

  assign n_clamped = (i_POINTS_NUM > 16'(SLOTS)) ? N_W'(SLOTS) : N_W'(i_POINTS_NUM);
  assign frame_end = vs_q & ~VGA_VS;
  assign selected  = frame_end && (decim_q == 8'd0);
  assign tx_vld    = (state_q != IDLE);
  assign tx_fire   = tx_vld && i_TX_READY;
  assign last_pt   = ((N_W'(pt_idx_q) + N_W'(1)) == n_q);

  // Byte mux reads only registered state, so data holds steady while stalled.
  always_comb begin
    tx_dat = 8'h00;
    case (state_q)
      HDR:     tx_dat = PKT_HEADER;
      FCNT:    tx_dat = fc_q;
      NUM:     tx_dat = 8'(n_q);
      PT:      tx_dat = coord_byte(16'(h_q[pt_idx_q]), 16'(v_q[pt_idx_q]), byte_idx_q);
      CHK:     tx_dat = chk_q;
      default: tx_dat = 8'h00;
    endcase
  end

  always_comb begin
    vs_d        = VGA_VS;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    decim_d     = decim_q;
    h_d         = h_q;
    v_d         = v_q;
    n_d         = n_q;
    fc_d        = fc_q;
    pt_idx_d    = pt_idx_q;
    byte_idx_d  = byte_idx_q;
    chk_d       = chk_q;

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      decim_d     = (decim_q == DECIM_LAST) ? 8'd0 : decim_q + 8'd1;
    end

    // The CHK-accept cycle still counts as busy, so a coincident frame is dropped.
    if (selected && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (tx_fire && ((state_q == FCNT) || (state_q == NUM) || (state_q == PT))) begin
      chk_d = chk_q ^ tx_dat;
    end

    case (state_q)
      IDLE: begin
        if (selected) begin
          h_d        = h_in;
          v_d        = v_in;
          n_d        = n_clamped;
          fc_d       = frame_cnt_q[7:0];
          pt_idx_d   = 2'd0;
          byte_idx_d = 2'd0;
          chk_d      = 8'h00;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (tx_fire) state_d = FCNT;
      end
      FCNT: begin
        if (tx_fire) state_d = NUM;
      end
      NUM: begin
        if (tx_fire) state_d = (n_q == '0) ? CHK : PT;
      end
      PT: begin
        if (tx_fire) begin
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            if (last_pt) state_d = CHK;
            else         pt_idx_d = pt_idx_q + 2'd1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      CHK: begin
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_q        <= 1'b0;
      state_q     <= IDLE;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      decim_q     <= 8'd0;
      for (int i = 0; i < NUM_POINTS_DEF; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      n_q         <= '0;
      fc_q        <= 8'd0;
      pt_idx_q    <= 2'd0;
      byte_idx_q  <= 2'd0;
      chk_q       <= 8'd0;
    end else begin
      vs_q        <= vs_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      decim_q     <= decim_d;
      h_q         <= h_d;
      v_q         <= v_d;
      n_q         <= n_d;
      fc_q        <= fc_d;
      pt_idx_q    <= pt_idx_d;
      byte_idx_q  <= byte_idx_d;
      chk_q       <= chk_d;
    end
  end

  assign o_TX_VALID  = tx_vld;
  assign o_TX_DATA   = tx_dat;
  assign o_BUSY      = tx_vld;
  assign o_FRAME_CNT = frame_cnt_q;
  assign o_DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_points_frame_scheduler.sv
// Directed bench for points_frame_scheduler: a queue-based packet model checked every
// cycle on two instances (decimation 1 and 3), plus hand-computed literal expectations.
module tb_points_frame_scheduler;

  typedef logic [7:0] byteq_t [$];

  logic        clk;
  logic        rst;
  logic        vs;
  logic [15:0] h [4];
  logic [15:0] v [4];
  logic [15:0] pnum;
  logic        rdy;

  logic [7:0]  d0, d3;
  logic        val0, val3, busy0, busy3;
  logic [15:0] fcnt0, fcnt3, drop0, drop3;

  int errors = 0;
  int checks = 0;

  byteq_t mq0, mq3;
  int     mfc [2];
  int     mdec [2];
  int     mdrop [2];
  int     decim_of [2];
  bit     mvs;
  bit     started;

  byteq_t log0, log3;
  int     vcnt0;

  points_frame_scheduler dut (
    .CLK(clk), .RST(rst), .VGA_VS(vs),
    .i_POINTS_H0(h[0]), .i_POINTS_H1(h[1]), .i_POINTS_H2(h[2]), .i_POINTS_H3(h[3]),
    .i_POINTS_V0(v[0]), .i_POINTS_V1(v[1]), .i_POINTS_V2(v[2]), .i_POINTS_V3(v[3]),
    .i_POINTS_NUM(pnum),
    .o_TX_DATA(d0), .o_TX_VALID(val0), .i_TX_READY(rdy), .o_BUSY(busy0),
    .o_FRAME_CNT(fcnt0), .o_DROP_CNT(drop0)
  );

  points_frame_scheduler #(.FRAME_DECIM(3)) dut3 (
    .CLK(clk), .RST(rst), .VGA_VS(vs),
    .i_POINTS_H0(h[0]), .i_POINTS_H1(h[1]), .i_POINTS_H2(h[2]), .i_POINTS_H3(h[3]),
    .i_POINTS_V0(v[0]), .i_POINTS_V1(v[1]), .i_POINTS_V2(v[2]), .i_POINTS_V3(v[3]),
    .i_POINTS_NUM(pnum),
    .o_TX_DATA(d3), .o_TX_VALID(val3), .i_TX_READY(rdy), .o_BUSY(busy3),
    .o_FRAME_CNT(fcnt3), .o_DROP_CNT(drop3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole packet as the wire should carry it, built from the current inputs.
  function automatic byteq_t build_pkt(input logic [7:0] fc);
    byteq_t     p;
    logic [7:0] x;
    logic [7:0] b [4];
    int         n;
    n = (pnum > 16'd4) ? 4 : int'(pnum);
    p.push_back(8'hA5);
    p.push_back(fc);
    p.push_back(8'(n));
    x = fc ^ 8'(n);
    for (int k = 0; k < n; k++) begin
      b[0] = h[k][15:8];
      b[1] = h[k][7:0];
      b[2] = v[k][15:8];
      b[3] = v[k][7:0];
      for (int j = 0; j < 4; j++) begin
        p.push_back(b[j]);
        x = x ^ b[j];
      end
    end
    p.push_back(x);
    return p;
  endfunction

  // Reference model: a packet is a queue that drains one byte per ready cycle.
  always @(posedge clk) begin
    bit fe;
    bit busy;
    started = 1'b1;
    if (rst) begin
      mq0.delete();
      mq3.delete();
      for (int i = 0; i < 2; i++) begin
        mfc[i] = 0; mdec[i] = 0; mdrop[i] = 0;
      end
      mvs = 1'b0;
    end else begin
      fe = mvs && !vs;
      for (int i = 0; i < 2; i++) begin
        busy = (i == 0) ? (mq0.size() != 0) : (mq3.size() != 0);
        if (busy && rdy) begin
          if (i == 0) void'(mq0.pop_front());
          else        void'(mq3.pop_front());
        end
        if (fe) begin
          if (mdec[i] == 0) begin
            if (busy) begin
              if (mdrop[i] < 65535) mdrop[i]++;
            end else if (i == 0) begin
              mq0 = build_pkt(8'(mfc[i] % 256));
            end else begin
              mq3 = build_pkt(8'(mfc[i] % 256));
            end
          end
          mfc[i]  = (mfc[i] + 1) % 65536;
          mdec[i] = (mdec[i] + 1) % decim_of[i];
        end
      end
      mvs = vs;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (val0 && rdy) log0.push_back(d0);
      if (val3 && rdy) log3.push_back(d3);
      if (val0) vcnt0++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid0", val0, mq0.size() != 0);
      check("busy0", busy0, mq0.size() != 0);
      if (mq0.size() != 0) check("data0", d0, mq0[0]);
      check("frame_cnt0", fcnt0, mfc[0]);
      check("drop_cnt0", drop0, mdrop[0]);
      check("valid3", val3, mq3.size() != 0);
      check("busy3", busy3, mq3.size() != 0);
      if (mq3.size() != 0) check("data3", d3, mq3[0]);
      check("frame_cnt3", fcnt3, mfc[1]);
      check("drop_cnt3", drop3, mdrop[1]);
    end
  end

  task automatic frame_pulse();
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy0 && !busy3) break;
    end
    check("idle_timeout", (busy0 || busy3), 1'b0);
  endtask

  task automatic wait_log0(input int cnt);
    for (int k = 0; k < 100 && log0.size() < cnt; k++) @(negedge clk);
    check("log0_reach", log0.size(), cnt);
  endtask

  initial begin
    logic [7:0] exp1 [8];
    logic [7:0] exp4 [8];
    logic [7:0] expd [8];
    decim_of[0] = 1;
    decim_of[1] = 3;
    started = 1'b0;
    vcnt0 = 0;
    rst = 1'b1; vs = 1'b0; rdy = 1'b1; pnum = 16'd0;
    for (int i = 0; i < 4; i++) begin h[i] = 16'd0; v[i] = 16'd0; end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", val0, 1'b0);
    check("rst_data", d0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_fcnt", fcnt0, 16'd0);
    check("rst_drop", drop0, 16'd0);
    // VS low after reset release must not look like a falling edge.
    repeat (3) @(negedge clk);
    check("no_fe_after_rst", fcnt0, 16'd0);
    vs = 1'b1;
    repeat (2) @(negedge clk);

    // One point, first frame.
    h[0] = 16'h0140; v[0] = 16'h00F0; pnum = 16'd1;
    log0.delete(); vcnt0 = 0;
    frame_pulse();
    wait_idle();
    exp1 = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h40, 8'h00, 8'hF0, 8'hB0};
    check("p1_len", log0.size(), 8);
    for (int i = 0; i < 8 && i < log0.size(); i++) check("p1_byte", log0[i], exp1[i]);
    check("p1_cycles", vcnt0, 8);
    check("p1_busy_after", busy0, 1'b0);

    // Frames 1..5 with no points; the sixth frame is pinned.
    pnum = 16'd0;
    for (int f = 1; f < 6; f++) begin
      log0.delete();
      frame_pulse();
      wait_idle();
    end
    check("p0_len", log0.size(), 4);
    if (log0.size() == 4) begin
      check("p0_b0", log0[0], 8'hA5);
      check("p0_b1", log0[1], 8'h05);
      check("p0_b2", log0[2], 8'h00);
      check("p0_b3", log0[3], 8'h05);
    end
    check("fcnt_after6", fcnt0, 16'd6);

    // Count clamps to 4; inputs changed mid-packet must not leak in.
    h[0] = 16'h1234; v[0] = 16'h5678;
    h[1] = 16'h0001; v[1] = 16'h00FF;
    h[2] = 16'hABCD; v[2] = 16'hEF01;
    h[3] = 16'h8000; v[3] = 16'h7FFF;
    pnum = 16'd7;
    log0.delete();
    frame_pulse();
    h[0] = 16'hDEAD; v[3] = 16'hBEEF; pnum = 16'd2;
    wait_idle();
    check("p7_len", log0.size(), 20);
    if (log0.size() == 20) begin
      check("p7_fc", log0[1], 8'h06);
      check("p7_n", log0[2], 8'h04);
      check("p7_h0hi", log0[3], 8'h12);
      check("p7_v3lo", log0[18], 8'hFF);
      check("p7_chk", log0[19], 8'h7C);
    end

    // Stall on the fourth byte with a dropped frame during the stall.
    h[0] = 16'h0102; v[0] = 16'h0304; pnum = 16'd1;
    log0.delete();
    frame_pulse();
    wait_log0(3);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", val0, 1'b1);
      check("stall_data", d0, 8'h01);
      if (k == 0) vs = 1'b0;
      if (k == 1) vs = 1'b1;
    end
    rdy = 1'b1;
    wait_idle();
    exp4 = '{8'hA5, 8'h07, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    check("p4_len", log0.size(), 8);
    for (int i = 0; i < 8 && i < log0.size(); i++) check("p4_byte", log0[i], exp4[i]);
    check("p4_drop", drop0, 16'd1);
    check("p4_fcnt", fcnt0, 16'd9);

    // Decimation by 3 from a clean reset over six frames.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pnum = 16'd0;
    log3.delete();
    for (int f = 0; f < 6; f++) begin
      frame_pulse();
      wait_idle();
    end
    expd = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h03, 8'h00, 8'h03};
    check("dec_len", log3.size(), 8);
    for (int i = 0; i < 8 && i < log3.size(); i++) check("dec_byte", log3[i], expd[i]);
    check("dec_drop", drop3, 16'd0);
    check("dec_fcnt", fcnt3, 16'd6);

    // Reset while the fifth byte is on the bus.
    h[0] = 16'h1111; v[0] = 16'h2222; h[1] = 16'h3333; v[1] = 16'h4444;
    pnum = 16'd2;
    log0.delete();
    frame_pulse();
    wait_log0(4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", val0, 1'b0);
    check("mid_rst_fcnt", fcnt0, 16'd0);
    check("mid_rst_drop", drop0, 16'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pnum = 16'd1;
    log0.delete();
    frame_pulse();
    wait_idle();
    check("fresh_len", log0.size(), 8);
    if (log0.size() == 8) begin
      check("fresh_hdr", log0[0], 8'hA5);
      check("fresh_fc", log0[1], 8'h00);
      check("fresh_chk", log0[7], 8'h00 ^ 8'h01 ^ 8'h11 ^ 8'h11 ^ 8'h22 ^ 8'h22);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/points_frame_scheduler.md
# points_frame_scheduler

Per-frame sequencer that sits behind FIND_MULTI_POINTS in the DE10-Nano D8M capture path. At every end of frame (VGA_VS falling edge) it snapshots the detected point coordinates and count. It then serialises them as a framed byte packet over a valid/ready byte stream toward the UART/host transmitter. It also decimates frames, counts frames and counts frames dropped while a packet is still in flight.

## Interface
- NUM_POINTS, 4: point slots supplied by the finder.
- COORD_W, 16: coordinate width in bits; the block transmits exactly 2 bytes per coordinate.
- FRAME_DECIM, 1: transmit one of every FRAME_DECIM frames. Valid range is 1..255.

Ports:
- CLK  in  1  pixel clock, shared with FIND_MULTI_POINTS.
- RST  in  1  synchronous, active-high reset.
- VGA_VS  in  1  frame-active strobe. A falling edge marks the end of a frame.
- i_POINTS_H0..H3, i_POINTS_V0..V3  in  16 each  finder coordinates. Valid at the VS falling edge.
- i_POINTS_NUM  in  16  number of valid points.
- o_TX_DATA  out  8  packet byte.
- o_TX_VALID  out  1  o_TX_DATA is valid.
- i_TX_READY  in  1  downstream accepts the byte.
- o_BUSY  out  1  a packet is in flight (state is not IDLE).
- o_FRAME_CNT  out  16  count of VS falling edges seen. Wraps from 0xFFFF to 0.
- o_DROP_CNT  out  16  count of selected frames discarded while busy. Saturates at 0xFFFF.

## Operation
- Edge detect:
  - vs_d <= VGA_VS each cycle.
  - frame_end = vs_d & ~VGA_VS.
  - Rising edges of VGA_VS are ignored.
- On each frame_end:
  - o_FRAME_CNT increments.
  - decim_cnt advances modulo FRAME_DECIM.
  - The frame is "selected" when decim_cnt == 0, evaluated before the advance.
- If a frame is selected and the state is IDLE:
  - Snapshot all coordinates.
  - Snapshot n = min(i_POINTS_NUM, NUM_POINTS).
  - Snapshot fc = o_FRAME_CNT[7:0], taken before the increment.
  - Enter HDR.
- If a frame is selected and the state is not IDLE:
  - o_DROP_CNT increments (saturating).
  - The packet in flight is not disturbed.
- Packet byte order:
  - 0xA5
  - fc
  - n
  - for each point k = 0..n-1: H[15:8], H[7:0], V[15:8], V[7:0]
  - CHK
- CHK is the XOR of every byte after the header. Packet length is 4 + 4n bytes.
- FSM states: IDLE, HDR, FCNT, NUM, PT, CHK.
  - PT uses a point index 0..n-1 and a byte index 0..3.
  - NUM goes to CHK directly when n == 0.
  - PT goes to CHK after byte 3 of point n-1.
  - CHK goes to IDLE on accept.
  - A frame_end in the same cycle as the CHK accept counts as busy and is dropped.
- Handshake:
  - A byte advances only on o_TX_VALID & i_TX_READY.
  - While o_TX_VALID is high and i_TX_READY is low, o_TX_DATA is held stable.
  - o_TX_VALID never deasserts mid-packet.
- The running XOR is updated on each accepted byte, excluding the header.

## Timing
- Reset values:
  - o_TX_VALID = 0, o_TX_DATA = 0x00, o_BUSY = 0.
  - o_FRAME_CNT = 0, o_DROP_CNT = 0.
  - vs_d = 0, decim_cnt = 0, state = IDLE.
- Snapshot latency: the snapshot is taken at the first CLK edge that samples VGA_VS = 0 with vs_d = 1. o_TX_VALID = 1 with 0xA5 is visible right after that same edge.
- Throughput: one byte per cycle when i_TX_READY is held high. A 2-point packet occupies exactly 12 cycles.
- Reset mid-packet: at the next edge o_TX_VALID = 0 and state = IDLE. The partial packet is abandoned; there is no tail and no checksum.
- Reset release with VGA_VS = 0: no frame_end is generated until VGA_VS has been sampled high.
- Inputs are sampled only at the snapshot. Later changes to i_POINTS_* have no effect on the packet in flight.

## Structure
- Package points_sched_pkg holds:
  - PKT_HEADER = 8'hA5.
  - The state enum (IDLE, HDR, FCNT, NUM, PT, CHK).
  - NUM_POINTS_DEF = 4.
- Single module; no sub-module. The edge detector, snapshot registers, byte mux and FSM are all inline.

## Test plan
- One point, H0 = 0x0140, V0 = 0x00F0, NUM = 1, ready held high, first frame -> bytes A5 00 01 01 40 00 F0 B0 on consecutive cycles, then o_BUSY = 0.
- NUM = 0 on the sixth frame -> A5 05 00 05; o_FRAME_CNT reads 6 afterwards.
- NUM = 7 with 4 slots populated -> count byte is 04 and exactly 4 points are sent (20 bytes).
- Hold i_TX_READY low for 3 cycles on byte 4, and raise a second VS falling edge during the packet -> o_TX_DATA is stable, o_DROP_CNT = 1, o_FRAME_CNT advances, and the packet finishes unchanged.
- FRAME_DECIM = 3 over 6 frames -> packets only for frames 0 and 3 (fc bytes 00 and 03), o_DROP_CNT = 0.
- RST asserted on byte 5 -> o_TX_VALID = 0 next cycle and counters are 0. The next frame emits a fresh packet with fc = 00.
